// File: rtl/m_memif_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m_memif_pkg : shared encodings, address map and legality check for m_memif
// Rev 1.0
// ----------------------------------------------------------------------------
package m_memif_pkg;

    localparam logic [1:0] C_OP_W = 2'd0;
    localparam logic [1:0] C_OP_H = 2'd1;
    localparam logic [1:0] C_OP_B = 2'd2;

    localparam logic [4:0] C_EXC_NONE = 5'd0;
    localparam logic [4:0] C_EXC_ADEL = 5'd4;
    localparam logic [4:0] C_EXC_ADES = 5'd5;

    localparam logic [31:0] C_DM_HI   = 32'h0000_2FFF;
    localparam logic [31:0] C_TC0_LO  = 32'h0000_7F00;
    localparam logic [31:0] C_TC0_HI  = 32'h0000_7F0B;
    localparam logic [31:0] C_TC1_LO  = 32'h0000_7F10;
    localparam logic [31:0] C_TC1_HI  = 32'h0000_7F1B;
    localparam logic [31:0] C_TC0_CNT = 32'h0000_7F08;
    localparam logic [31:0] C_TC1_CNT = 32'h0000_7F18;

    localparam int C_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Timer registers are word-only, and their count registers are read-only.
    function automatic logic addr_illegal(input logic [1:0] op, input logic [31:0] a,
                                          input logic is_store);
        logic in_dm;
        logic in_tc;
        logic misal;
        in_dm = (a <= C_DM_HI);
        in_tc = ((a >= C_TC0_LO) && (a <= C_TC0_HI)) || ((a >= C_TC1_LO) && (a <= C_TC1_HI));
        misal = ((op == C_OP_W) && (a[1:0] != 2'b00)) || ((op == C_OP_H) && a[0]);
        return misal || (op == 2'd3) || !(in_dm || in_tc) || (in_tc && (op != C_OP_W)) ||
               (is_store && ((a == C_TC0_CNT) || (a == C_TC1_CNT)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_memif_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m_memif_if : external data bus between m_memif (master) and memory (slave)
// Rev 1.0
// ----------------------------------------------------------------------------
interface m_memif_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic        bus_we;
    logic        bus_req;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_byteen, bus_we, bus_req,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_byteen, bus_we, bus_req,
        output bus_ack, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/m_memif_be.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m_memif_be : store byte-enable generation and lane replication of store data
// Rev 1.0
// ----------------------------------------------------------------------------
module m_memif_be
    import m_memif_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  sop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    output logic [3:0]  byteen,
    output logic [31:0] wdata
);

    always_comb begin
        byteen = 4'b0000;
        wdata  = 32'h0;
        if (is_store) begin
            case (sop)
                C_OP_W: begin
                    byteen = 4'b1111;
                    wdata  = wd;
                end
                C_OP_H: begin
                    byteen = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata  = {2{wd[15:0]}};
                end
                C_OP_B: begin
                    byteen = 4'b0001 << addr_lo;
                    wdata  = {4{wd[7:0]}};
                end
                default: begin
                    byteen = 4'b0000;
                    wdata  = 32'h0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_memif.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m_memif : M-stage load/store bus master with stall, timeout and address faults
// Rev 1.0
// ----------------------------------------------------------------------------
module m_memif
    import m_memif_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Lop,
    input  logic [1:0]  Sop,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        Flush,
    m_memif_if.master   bus,
    output logic [31:0] RD,
    output logic        Stall,
    output logic [4:0]  ExcCode
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_abort;
    logic          r_flushed;

    logic          w_op;
    logic          w_illegal;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;

    assign w_op      = (MemRead | MemWrite) & ~Flush;
    assign w_illegal = addr_illegal(MemWrite ? Sop : Lop, A, MemWrite);

    m_memif_be u_be (
        .is_store (MemWrite),
        .sop      (Sop),
        .addr_lo  (A[1:0]),
        .wd       (WD),
        .byteen   (w_be),
        .wdata    (w_wdata)
    );

    always_comb begin
        Stall   = ~reset & w_op & (r_state != ST_DONE) & ~w_illegal;
        ExcCode = C_EXC_NONE;
        if (!reset) begin
            if ((r_state == ST_IDLE) && w_op && w_illegal) begin
                ExcCode = MemWrite ? C_EXC_ADES : C_EXC_ADEL;
            end else if ((r_state == ST_DONE) && r_abort && !(r_flushed | Flush)) begin
                ExcCode = bus.bus_we ? C_EXC_ADES : C_EXC_ADEL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_abort        <= 1'b0;
            r_flushed      <= 1'b0;
            RD             <= 32'h0;
            bus.bus_addr   <= 32'h0;
            bus.bus_wdata  <= 32'h0;
            bus.bus_byteen <= 4'b0000;
            bus.bus_we     <= 1'b0;
            bus.bus_req    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_abort   <= 1'b0;
                    r_flushed <= 1'b0;
                    if (w_op && !w_illegal) begin
                        bus.bus_addr   <= {A[31:2], 2'b00};
                        bus.bus_we     <= MemWrite;
                        bus.bus_byteen <= w_be;
                        bus.bus_wdata  <= w_wdata;
                        bus.bus_req    <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (Flush) begin
                        r_flushed <= 1'b1;
                    end
                    // A flushed instruction still finishes on the bus but its data is dropped.
                    if (bus.bus_ack) begin
                        if (!bus.bus_we && !(r_flushed | Flush)) begin
                            RD <= bus.bus_rdata;
                        end
                        bus.bus_req <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_abort     <= 1'b1;
                        bus.bus_req <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    bus.bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_memif.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_m_memif : scoreboard bench for m_memif bus transactions, faults and reset
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_m_memif;
    import m_memif_pkg::*;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, Flush;
    logic [1:0]  Lop, Sop;
    logic [31:0] A, WD, RD;
    logic        Stall;
    logic [4:0]  ExcCode;

    m_memif_if bus ();

    m_memif #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Lop      (Lop),
        .Sop      (Sop),
        .A        (A),
        .WD       (WD),
        .Flush    (Flush),
        .bus      (bus),
        .RD       (RD),
        .Stall    (Stall),
        .ExcCode  (ExcCode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } txn_t;

    txn_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rd;

    int          o_stall, o_req;
    logic [31:0] o_addr, o_wdata, o_rd;
    logic [3:0]  o_be;
    logic        o_we, o_unstable, o_done_stall;
    logic [4:0]  o_exc;

    task automatic apply(input logic st, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
        MemRead  = !st;
        MemWrite = st;
        Lop      = st ? 2'd0 : op;
        Sop      = st ? op : 2'd0;
        A        = a;
        WD       = wd;
    endtask

    task automatic idle_inputs();
        MemRead = 0; MemWrite = 0; Flush = 0; Lop = 0; Sop = 0; A = 0; WD = 0;
    endtask

    // Reference bus transaction built from the store/load rules.
    task automatic push_exp(input logic st, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] wd);
        txn_t t;
        t.addr  = {a[31:2], 2'b00};
        t.we    = st;
        t.be    = 4'b0000;
        t.wdata = 32'h0;
        if (st) begin
            if (op == C_OP_W) begin t.be = 4'b1111; t.wdata = wd; end
            else if (op == C_OP_H) begin t.be = a[1] ? 4'b1100 : 4'b0011; t.wdata = {wd[15:0], wd[15:0]}; end
            else begin t.be = 4'b0001 << a[1:0]; t.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
        end
        exp_q.push_back(t);
    endtask

    // Drives one accepted transaction to its DONE cycle; ack_after<0 means never ack.
    task automatic run_txn(input int ack_after, input int flush_at, input logic [31:0] rdata);
        bit done = 0;
        int cyc = 0;
        o_stall = 0; o_req = 0; o_unstable = 0; o_done_stall = 1'bx;
        o_exc = 5'bx; o_rd = 32'bx;
        bus.bus_rdata = rdata;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (Stall) o_stall++;
            if (bus.bus_req) begin
                if (o_req == 0) begin
                    o_addr = bus.bus_addr; o_be = bus.bus_byteen;
                    o_wdata = bus.bus_wdata; o_we = bus.bus_we;
                end else if ({o_addr, o_be, o_wdata, o_we} !==
                             {bus.bus_addr, bus.bus_byteen, bus.bus_wdata, bus.bus_we}) begin
                    o_unstable = 1;
                end
                o_req++;
            end else if (o_req > 0) begin
                o_exc = ExcCode; o_rd = RD; o_done_stall = Stall;
                done = 1;
            end
            @(posedge clk);
            #1;
            bus.bus_ack = bus.bus_req && (ack_after >= 0) && (o_req == ack_after);
            Flush = (flush_at > 0) && bus.bus_req && (o_req + 1 == flush_at);
            if (done) idle_inputs();
        end
        bus.bus_ack = 0;
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL txn_bound: no DONE within %0d cycles, req cycles %0d", cyc, o_req);
            idle_inputs();
        end
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); bus.bus_ack = 0; bus.bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({RD, bus.bus_addr, bus.bus_wdata, bus.bus_byteen, bus.bus_we, bus.bus_req, Stall, ExcCode} !== 111'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got RD=%h addr=%h wdata=%h be=%b we=%b req=%b stall=%b exc=%0d, need all 0",
                     RD, bus.bus_addr, bus.bus_wdata, bus.bus_byteen, bus.bus_we, bus.bus_req, Stall, ExcCode);
        end
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        n_checks++;
        if ({bus.bus_req, Stall, ExcCode, RD} !== 39'h0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got req=%b stall=%b exc=%0d RD=%h, need 0", bus.bus_req, Stall, ExcCode, RD);
        end
        @(posedge clk); #1;
        exp_rd = 32'h0;
    endtask

    task automatic test_sw_basic();
        txn_t e;
        apply(1, C_OP_W, 32'h10, 32'hDEAD_BEEF);
        push_exp(1, C_OP_W, 32'h10, 32'hDEAD_BEEF);
        run_txn(0, 0, 32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if ({o_addr, o_be, o_wdata, o_we} !== {e.addr, e.be, e.wdata, e.we}) begin
            n_errors++;
            $display("FAIL sw_bus: got %h/%b/%h/%b need %h/%b/%h/%b", o_addr, o_be, o_wdata, o_we, e.addr, e.be, e.wdata, e.we);
        end
        n_checks++;
        if (o_stall !== 2 || o_req !== 1) begin
            n_errors++;
            $display("FAIL sw_latency: stall %0d req %0d, need 2 and 1", o_stall, o_req);
        end
        n_checks++;
        if (o_exc !== C_EXC_NONE || o_done_stall !== 1'b0 || o_rd !== exp_rd) begin
            n_errors++;
            $display("FAIL sw_done: exc %0d stall %b RD %h, need 0 0 %h", o_exc, o_done_stall, o_rd, exp_rd);
        end
    endtask

    task automatic test_lb_wait();
        txn_t e;
        apply(0, C_OP_B, 32'h0203, 32'h0);
        push_exp(0, C_OP_B, 32'h0203, 32'h0);
        run_txn(4, 0, 32'h8011_2233);
        exp_rd = 32'h8011_2233;
        e = exp_q.pop_front();
        n_checks++;
        if ({o_addr, o_be, o_we} !== {e.addr, e.be, e.we} || o_unstable !== 1'b0) begin
            n_errors++;
            $display("FAIL lb_bus: got %h/%b/%b unstable=%b need %h/%b/%b stable", o_addr, o_be, o_we, o_unstable, e.addr, e.be, e.we);
        end
        n_checks++;
        if (o_stall !== 6 || o_req !== 5) begin
            n_errors++;
            $display("FAIL lb_latency: stall %0d req %0d, need 6 and 5", o_stall, o_req);
        end
        n_checks++;
        if (o_rd !== exp_rd || o_exc !== C_EXC_NONE) begin
            n_errors++;
            $display("FAIL lb_rd: RD %h exc %0d, need %h 0", o_rd, o_exc, exp_rd);
        end
    endtask

    task automatic test_illegal();
        logic        st[8]  = '{0, 1, 0, 0, 1, 1, 0, 1};
        logic [1:0]  op[8]  = '{C_OP_W, C_OP_H, C_OP_H, C_OP_B, C_OP_W, C_OP_W, C_OP_W, C_OP_B};
        logic [31:0] adr[8] = '{32'h6, 32'h7F00, 32'h7F02, 32'h3000, 32'h7F08, 32'h7F18, 32'h7F0C, 32'h8000_0000};
        for (int i = 0; i < 8; i++) begin
            logic [4:0] want;
            want = st[i] ? 5'd5 : 5'd4;
            apply(st[i], op[i], adr[i], 32'h1234_5678);
            @(negedge clk);
            n_checks++;
            if (ExcCode !== want || Stall !== 1'b0) begin
                n_errors++;
                $display("FAIL illegal_%0d: exc %0d stall %b, need %0d 0 (addr %h)", i, ExcCode, Stall, want, adr[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus.bus_req !== 1'b0) begin
                n_errors++;
                $display("FAIL illegal_req_%0d: bus_req %b, need 0", i, bus.bus_req);
            end
            idle_inputs();
        end
    endtask

    task automatic test_byteen();
        logic        st[6]  = '{1, 1, 1, 1, 1, 0};
        logic [1:0]  op[6]  = '{C_OP_B, C_OP_H, C_OP_H, C_OP_B, C_OP_W, C_OP_W};
        logic [31:0] adr[6] = '{32'h1, 32'h2, 32'h0, 32'h3, 32'h7F04, 32'h7F18};
        logic [31:0] wd[6]  = '{32'hAB, 32'h1234_CDEF, 32'h0000_5A5A, 32'hFFFF_FF3C, 32'h5, 32'h0};
        for (int i = 0; i < 6; i++) begin
            txn_t e;
            apply(st[i], op[i], adr[i], wd[i]);
            push_exp(st[i], op[i], adr[i], wd[i]);
            run_txn(i % 3, 0, 32'h0000_0077 + i);
            if (!st[i]) exp_rd = 32'h0000_0077 + i;
            e = exp_q.pop_front();
            n_checks++;
            if ({o_addr, o_be, o_we} !== {e.addr, e.be, e.we} || (e.we && o_wdata !== e.wdata)) begin
                n_errors++;
                $display("FAIL be_%0d: got %h/%b/%h/%b need %h/%b/%h/%b", i, o_addr, o_be, o_wdata, o_we, e.addr, e.be, e.wdata, e.we);
            end
            n_checks++;
            if (o_rd !== exp_rd || o_exc !== C_EXC_NONE) begin
                n_errors++;
                $display("FAIL be_done_%0d: RD %h exc %0d, need %h 0", i, o_rd, o_exc, exp_rd);
            end
        end
    endtask

    task automatic test_timeout();
        for (int s = 0; s < 2; s++) begin
            txn_t e;
            logic [4:0] want;
            want = (s == 1) ? 5'd5 : 5'd4;
            apply(s == 1, C_OP_W, 32'h0, 32'h99);
            push_exp(s == 1, C_OP_W, 32'h0, 32'h99);
            run_txn(-1, 0, 32'hFFFF_FFFF);
            e = exp_q.pop_front();
            n_checks++;
            if (o_req !== TO || o_addr !== e.addr || o_we !== e.we) begin
                n_errors++;
                $display("FAIL timeout_len_%0d: req cycles %0d addr %h we %b, need %0d %h %b", s, o_req, o_addr, o_we, TO, e.addr, e.we);
            end
            n_checks++;
            if (o_exc !== want || o_rd !== exp_rd) begin
                n_errors++;
                $display("FAIL timeout_exc_%0d: exc %0d RD %h, need %0d %h", s, o_exc, o_rd, want, exp_rd);
            end
        end
    endtask

    task automatic test_flush();
        txn_t e;
        apply(0, C_OP_W, 32'h100, 32'h0);
        Flush = 1;
        @(negedge clk);
        n_checks++;
        if (Stall !== 1'b0 || ExcCode !== C_EXC_NONE) begin
            n_errors++;
            $display("FAIL flush_idle: stall %b exc %0d, need 0 0", Stall, ExcCode);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_idle_req: bus_req %b, need 0", bus.bus_req);
        end
        Flush = 0;
        push_exp(0, C_OP_W, 32'h100, 32'h0);
        run_txn(-1, 1, 32'h0);
        e = exp_q.pop_front();
        n_checks++;
        if (o_req !== TO || o_addr !== e.addr || o_exc !== C_EXC_NONE) begin
            n_errors++;
            $display("FAIL flush_abort: req %0d addr %h exc %0d, need %0d %h 0", o_req, o_addr, o_exc, TO, e.addr);
        end
        apply(0, C_OP_W, 32'h104, 32'h0);
        push_exp(0, C_OP_W, 32'h104, 32'h0);
        run_txn(2, 2, 32'h1234_5678);
        e = exp_q.pop_front();
        n_checks++;
        if (o_req !== 3 || o_addr !== e.addr || o_exc !== C_EXC_NONE || o_rd !== exp_rd) begin
            n_errors++;
            $display("FAIL flush_ack: req %0d addr %h exc %0d RD %h, need 3 %h 0 %h", o_req, o_addr, o_exc, o_rd, e.addr, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic        st[3]  = '{1, 0, 1};
        logic [1:0]  op[3]  = '{C_OP_W, C_OP_W, C_OP_B};
        logic [31:0] adr[3] = '{32'h20, 32'h24, 32'h2FFF};
        for (int i = 0; i < 3; i++) begin
            txn_t e;
            apply(st[i], op[i], adr[i], 32'h0BAD_F00D + i);
            push_exp(st[i], op[i], adr[i], 32'h0BAD_F00D + i);
            run_txn(0, 0, 32'hCAFE_F00D);
            if (!st[i]) exp_rd = 32'hCAFE_F00D;
            e = exp_q.pop_front();
            n_checks++;
            if ({o_addr, o_be, o_we} !== {e.addr, e.be, e.we} || (e.we && o_wdata !== e.wdata) ||
                o_stall !== 2 || o_rd !== exp_rd) begin
                n_errors++;
                $display("FAIL b2b_%0d: got %h/%b/%h stall %0d RD %h, need %h/%b/%h stall 2 RD %h",
                         i, o_addr, o_be, o_wdata, o_stall, o_rd, e.addr, e.be, e.wdata, exp_rd);
            end
        end
    endtask

    task automatic test_reset_in_req();
        apply(0, C_OP_W, 32'h40, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (bus.bus_req !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_req_enter: bus_req %b, need 1", bus.bus_req);
        end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        exp_rd = 32'h0;
        n_checks++;
        if (bus.bus_req !== 1'b0 || RD !== exp_rd) begin
            n_errors++;
            $display("FAIL rst_in_req: bus_req %b RD %h, need 0 %h", bus.bus_req, RD, exp_rd);
        end
        bus.bus_ack = 1; bus.bus_rdata = 32'h5555_AAAA;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus.bus_req !== 1'b0 || Stall !== 1'b0 || ExcCode !== C_EXC_NONE || RD !== exp_rd) begin
                n_errors++;
                $display("FAIL late_ack: req %b stall %b exc %0d RD %h, need 0 0 0 %h", bus.bus_req, Stall, ExcCode, RD, exp_rd);
            end
            @(posedge clk); #1;
        end
        bus.bus_ack = 0;
    endtask

    initial begin
        test_reset();
        test_sw_basic();
        test_lb_wait();
        test_illegal();
        test_byteen();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_in_req();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_memif.md
M_MEMIF -- requirements
Module: m_memif

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles waiting for bus_ack before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 MemRead  in  1  M-stage load present; MemWrite  in  1  M-stage store present (never both).
REQ-005 Lop  in  2  load type: lw/lh/lb; Sop  in  2  store type: sw/sh/sb.
REQ-006 A  in  32  byte address; WD  in  32  store data (right-justified).
REQ-007 Flush  in  1  exception/interrupt flush of the M-stage instruction.
REQ-008 bus_addr  out  32, bus_wdata  out  32, bus_byteen  out  4, bus_we  out  1, bus_req  out  1: external data bus.
REQ-009 bus_ack  in  1, bus_rdata  in  32: bus completion and read word.
REQ-010 RD  out  32  registered raw read word, consumed by load-extension stage together with A.
REQ-011 Stall  out  1  freeze F/D/E/M; ExcCode  out  5  0 none, 4 AdEL, 5 AdES.

Function
REQ-012 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-013 Op present = (MemRead|MemWrite) & ~Flush; Stall = op present & state!=DONE & ~illegal.
REQ-014 Illegal load: lw A[1:0]!=0; lh A[0]!=0; address outside DM 0x0000-0x2FFF, TC0 0x7F00-0x7F0B, TC1 0x7F10-0x7F1B; lh/lb to timer range.
REQ-015 Illegal store: same alignment/range rules, plus sh/sb to timer range, plus any store to 0x7F08 or 0x7F18.
REQ-016 Illegal op in IDLE: ExcCode combinationally 4 (load) / 5 (store) that cycle, Stall=0, no bus transaction, state stays IDLE.
REQ-017 Legal op in IDLE: register bus_addr={A[31:2],2'b00}, bus_we, bus_byteen, bus_wdata; go REQ.
REQ-018 Byte enables: sw 1111; sh A[1]=0 0011, A[1]=1 1100; sb 0001<<A[1:0]; loads 0000.
REQ-019 Store data: sw WD; sh {WD[15:0],WD[15:0]}; sb {4{WD[7:0]}}.
REQ-020 REQ: bus_req=1, all bus outputs held stable; bus_ack sampled only in REQ.
REQ-021 bus_ack in REQ: capture bus_rdata into RD (loads only; stores leave RD unchanged), go DONE.
REQ-022 Timeout counter clears on entering REQ, increments each REQ cycle without ack; on reaching TIMEOUT, go DONE with abort flag, RD unchanged.
REQ-023 DONE lasts exactly one cycle: Stall=0, ExcCode=abort?(4 load / 5 store):0, then IDLE.
REQ-024 Minimum latency: accept T, bus_req at T+1, ack at T+1, DONE at T+2 (Stall high T, T+1).
REQ-025 Flush in IDLE suppresses issue; Flush in REQ has no bus effect, transaction completes, DONE ExcCode forced 0, result discarded.
REQ-026 bus_req low in IDLE and DONE; bus_we meaningful only when bus_req=1.

Reset
REQ-027 reset forces IDLE; counter 0; abort flag 0.
REQ-028 reset drives RD, bus_addr, bus_wdata to 0; bus_byteen 0000; bus_we, bus_req, Stall 0; ExcCode 0.
REQ-029 reset during REQ drops bus_req next edge; late bus_ack while IDLE ignored.

Structure
REQ-030 Lop/Sop encodings, ExcCode values, address range bounds, TIMEOUT default live in shared macro header.
REQ-031 Byte-enable/store-align logic is one combinational sub-module, M_BE; FSM, counter, capture registers in m_memif.

Verification
REQ-032 sw A=0x10, WD=0xDEADBEEF, ack on first REQ cycle -> bus_byteen 1111, bus_wdata 0xDEADBEEF, Stall high 2 cycles, ExcCode 0.
REQ-033 lb A=0x0203, bus_rdata 0x80112233, ack after 5 REQ cycles -> bus_addr 0x0200, RD 0x80112233 in DONE, Stall high 6 cycles.
REQ-034 lw A=0x0006 -> ExcCode 4 same cycle, Stall 0, bus_req never asserted; sh A=0x7F00 -> ExcCode 5.
REQ-035 sb A=0x0001, WD=0x000000AB -> bus_byteen 0010, bus_wdata 0xABABABAB; sh A=0x0002 -> 1100.
REQ-036 lw A=0x0, no ack, TIMEOUT=4 -> DONE after 4 REQ cycles, ExcCode 4, RD unchanged.
REQ-037 reset asserted in REQ -> next cycle IDLE, bus_req 0, RD 0; ack arriving after is ignored.
